mem_port_arbiter: RTL and testbench

- Arbitrates a single shared memory port between the instruction-fetch requester (IF) and the load/store requester (DATA).
- Targets the multi-cycle and pipelined core variants, where instruction and data memories collapse into one unified memory.
- Allows one outstanding transaction at a time.
- Priority goes to DATA, with an aging counter so IF cannot starve.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the two requester buses (instruction fetch
// and load/store) plus the shared memory port.
//   slave  : arbiter view (takes requests, drives grants/responses and mem_*)
//   master : environment view (requesters and memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // shared memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and load/store (DATA). One transaction in flight; DATA has priority, IF
// wins a tie after STARVE_LIMIT consecutive lost ties (0 = strict DATA).
// Ports:
//   clk, reset      clock, async active-high reset
//   bus (slave)     requester buses + memory port (see mem_port_arbiter_if)
//   busy            FSM not in IDLE
//   prot_err        sticky: mem_rvalid seen outside RESP
//   if_grant_cnt,
//   d_grant_cnt     grant counters, only with MEM_ARB_PERF_CNT_EN defined
//                   (otherwise tied to 0)
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                prot_err,
  output logic [31:0]         if_grant_cnt,
  output logic [31:0]         d_grant_cnt
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam int              SW  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   LIM = SW'(STARVE_LIMIT);

  logic [1:0]        state, owner;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              we_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              aged, if_win, d_win;

  // IF has lost enough ties to take the next one.
  assign aged = (STARVE_LIMIT != 0) && (starve_cnt == LIM);

  // Grants are decided combinationally in IDLE so the grant cycle is also
  // the cycle the request is latched; masked during reset so every output
  // reads 0 while it is held.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (state == S_IDLE && !reset) begin
      if_win = bus.if_req && (!bus.d_req || aged);
      d_win  = bus.d_req && !if_win;
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.mem_req   = (state == S_ISSUE);
  assign bus.mem_we    = bus.mem_req & we_q;
  assign bus.mem_be    = bus.mem_req ? be_q : 4'h0;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= OWN_NONE;
      starve_cnt  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      prot_err    <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (bus.mem_rvalid && state != S_RESP) prot_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (if_win) begin
            addr_q     <= bus.if_addr;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= 4'hF;
            owner      <= OWN_IF;
            starve_cnt <= '0;
            state      <= S_ISSUE;
          end else if (d_win) begin
            addr_q  <= bus.d_addr;
            we_q    <= bus.d_we;
            wdata_q <= bus.d_wdata;
            be_q    <= bus.d_be;
            owner   <= OWN_D;
            state   <= S_ISSUE;
            // IF lost a tie: age it, saturating at the limit.
            if (bus.if_req && starve_cnt != LIM) starve_cnt <= starve_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.mem_ready) begin
            if (we_q) begin
              // only DATA can own a write; ack it with zero read data
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= '0;
              owner      <= OWN_NONE;
              state      <= S_IDLE;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.mem_rvalid) begin
            if (owner == OWN_IF) begin
              if_rdata_q  <= bus.mem_rdata;
              if_rvalid_q <= 1'b1;
            end else begin
              d_rdata_q  <= bus.mem_rdata;
              d_rvalid_q <= 1'b1;
            end
            owner <= OWN_NONE;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] if_cnt_q, d_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_cnt_q <= '0;
      d_cnt_q  <= '0;
    end else begin
      if (if_win) if_cnt_q <= if_cnt_q + 32'd1;
      if (d_win)  d_cnt_q  <= d_cnt_q + 32'd1;
    end
  end

  assign if_grant_cnt = if_cnt_q;
  assign d_grant_cnt  = d_cnt_q;
`else
  assign if_grant_cnt = '0;
  assign d_grant_cnt  = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bi ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();

  logic        busy, prot_err, busy0, prot_err0;
  logic [31:0] if_cnt, d_cnt, if_cnt0, d_cnt0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .bus(bi), .busy(busy), .prot_err(prot_err),
    .if_grant_cnt(if_cnt), .d_grant_cnt(d_cnt));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .busy(busy0), .prot_err(prot_err0),
    .if_grant_cnt(if_cnt0), .d_grant_cnt(d_cnt0));

  // memory side for dut: manual (directed) or auto (always ready, read data
  // one cycle after acceptance)
  logic        auto_mem = 1'b0;
  logic        man_ready = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        arv, r0v;
  logic [31:0] ardata, r0data;

  assign bi.mem_ready  = auto_mem ? 1'b1 : man_ready;
  assign bi.mem_rvalid = auto_mem ? arv : man_rvalid;
  assign bi.mem_rdata  = auto_mem ? ardata : man_rdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      arv <= 1'b0; ardata <= '0;
    end else begin
      arv    <= bi.mem_req && bi.mem_ready && !bi.mem_we;
      ardata <= ~bi.mem_addr;
    end
  end

  // dut0: both requesters driven by one shared signal, memory always in auto mode
  logic both0 = 1'b0;
  assign b0.if_req     = both0;
  assign b0.if_addr    = 32'h40;
  assign b0.d_req      = both0;
  assign b0.d_we       = 1'b0;
  assign b0.d_addr     = 32'h80;
  assign b0.d_wdata    = '0;
  assign b0.d_be       = 4'hF;
  assign b0.mem_ready  = 1'b1;
  assign b0.mem_rvalid = r0v;
  assign b0.mem_rdata  = r0data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      r0v <= 1'b0; r0data <= '0;
    end else begin
      r0v    <= b0.mem_req && !b0.mem_we;
      r0data <= b0.mem_addr;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] seq;
  int         n_gnt, both_hi, ni0, nd0;

  initial begin
    bi.if_req = 1'b0; bi.if_addr = '0;
    bi.d_req = 1'b0; bi.d_we = 1'b0; bi.d_addr = '0; bi.d_wdata = '0; bi.d_be = '0;

    // ---- reset state
    step(); step();
    chk("rst_if_gnt", 32'(bi.if_gnt), 0);
    chk("rst_mem_req", 32'(bi.mem_req), 0);
    chk("rst_mem_addr", bi.mem_addr, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_prot_err", 32'(prot_err), 0);
    chk("rst_if_rdata", bi.if_rdata, 0);
    reset = 1'b0;

    // ---- IF read, immediate ready, data one cycle after acceptance
    man_ready = 1'b1;
    bi.if_req = 1'b1; bi.if_addr = 32'h10;
    #1;
    chk("rd_if_gnt_c0", 32'(bi.if_gnt), 1);
    chk("rd_d_gnt_c0", 32'(bi.d_gnt), 0);
    step();
    bi.if_req = 1'b0; bi.if_addr = 32'hFFFF_FFFF;
    #1;
    chk("rd_mem_req_c1", 32'(bi.mem_req), 1);
    chk("rd_mem_addr_c1", bi.mem_addr, 32'h10);
    chk("rd_mem_be_c1", 32'(bi.mem_be), 32'hF);
    chk("rd_mem_we_c1", 32'(bi.mem_we), 0);
    step();
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_mem_req_c2", 32'(bi.mem_req), 0);
    chk("rd_mem_be_c2", 32'(bi.mem_be), 0);
    step();
    man_rvalid = 1'b0; man_rdata = '0;
    #1;
    chk("rd_if_rvalid_c3", 32'(bi.if_rvalid), 1);
    chk("rd_if_rdata_c3", bi.if_rdata, 32'hDEAD_BEEF);
    chk("rd_busy_c3", 32'(busy), 0);
    step();
    chk("rd_if_rvalid_c4", 32'(bi.if_rvalid), 0);
    chk("rd_if_rdata_hold", bi.if_rdata, 32'hDEAD_BEEF);

    // ---- store with mem_ready low for 3 cycles
    man_ready = 1'b0;
    bi.d_req = 1'b1; bi.d_we = 1'b1; bi.d_addr = 32'h100;
    bi.d_wdata = 32'h1234_5678; bi.d_be = 4'b0011;
    #1;
    chk("st_d_gnt", 32'(bi.d_gnt), 1);
    chk("st_if_gnt", 32'(bi.if_gnt), 0);
    step();
    bi.d_req = 1'b0; bi.d_we = 1'b0; bi.d_wdata = 32'hFFFF_FFFF; bi.d_be = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) man_ready = 1'b1;
      #1;
      chk("st_mem_req", 32'(bi.mem_req), 1);
      chk("st_mem_we", 32'(bi.mem_we), 1);
      chk("st_mem_be", 32'(bi.mem_be), 32'h3);
      chk("st_mem_wdata", bi.mem_wdata, 32'h1234_5678);
      chk("st_mem_addr", bi.mem_addr, 32'h100);
      chk("st_d_rvalid_early", 32'(bi.d_rvalid), 0);
      step();
    end
    man_ready = 1'b0;
    #1;
    chk("st_d_rvalid", 32'(bi.d_rvalid), 1);
    chk("st_d_rdata", bi.d_rdata, 0);
    chk("st_mem_req_off", 32'(bi.mem_req), 0);
    chk("st_mem_we_off", 32'(bi.mem_we), 0);
    chk("st_busy", 32'(busy), 0);
    chk("st_if_rdata_kept", bi.if_rdata, 32'hDEAD_BEEF);
    step();
    chk("st_d_rvalid_pulse", 32'(bi.d_rvalid), 0);

    // ---- both requesting continuously, STARVE_LIMIT = 4
    auto_mem = 1'b1;
    bi.if_req = 1'b1; bi.if_addr = 32'h200;
    bi.d_req = 1'b1; bi.d_we = 1'b0; bi.d_addr = 32'h300;
    #1;
    seq = '0; n_gnt = 0; both_hi = 0;
    for (int cyc = 0; cyc < 200 && n_gnt < 10; cyc++) begin
      if (bi.if_gnt && bi.d_gnt) both_hi++;
      if (bi.if_gnt) begin seq[n_gnt] = 1'b1; n_gnt++; end
      else if (bi.d_gnt) n_gnt++;
      step();
    end
    bi.if_req = 1'b0; bi.d_req = 1'b0;
    chk("age_n_gnt", 32'(n_gnt), 10);
    chk("age_seq_DDDDIDDDDI", 32'(seq), 32'h210);
    chk("age_dual_gnt", 32'(both_hi), 0);
    for (int k = 0; k < 6; k++) step();
    chk("age_busy_end", 32'(busy), 0);

    // ---- grant counters: IF 1+2, DATA 1+8 so far
`ifdef MEM_ARB_PERF_CNT_EN
    chk("cnt_if", if_cnt, 3);
    chk("cnt_d", d_cnt, 9);
`else
    chk("cnt_if_off", if_cnt, 0);
    chk("cnt_d_off", d_cnt, 0);
`endif

    // ---- STARVE_LIMIT = 0: strict DATA priority over 20 transactions
    both0 = 1'b1;
    #1;
    ni0 = 0; nd0 = 0;
    for (int cyc = 0; cyc < 300 && nd0 < 20; cyc++) begin
      if (b0.if_gnt) ni0++;
      if (b0.d_gnt) nd0++;
      step();
    end
    both0 = 1'b0;
    chk("strict_d_grants", 32'(nd0), 20);
    chk("strict_if_grants", 32'(ni0), 0);

    // ---- protocol error, reset during RESP
    auto_mem = 1'b0; man_ready = 1'b1;
    step();
    man_rvalid = 1'b1;
    step();
    man_rvalid = 1'b0;
    #1;
    chk("perr_idle_set", 32'(prot_err), 1);
    bi.if_req = 1'b1; bi.if_addr = 32'h20;
    #1;
    chk("perr_if_gnt", 32'(bi.if_gnt), 1);
    step();
    bi.if_req = 1'b0;
    step();
    chk("perr_in_resp_busy", 32'(busy), 1);
    chk("perr_in_resp_req", 32'(bi.mem_req), 0);
    reset = 1'b1;
    #1;
    man_rvalid = 1'b1; man_rdata = 32'h5555_AAAA;
    #1;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_prot_err", 32'(prot_err), 0);
    chk("rstmid_if_rvalid", 32'(bi.if_rvalid), 0);
    chk("rstmid_if_rdata", bi.if_rdata, 0);
    chk("rstmid_mem_req", 32'(bi.mem_req), 0);
    chk("rstmid_if_cnt", if_cnt, 0);
    step(); step();
    man_rvalid = 1'b0; reset = 1'b0;
    step();
    chk("rstmid_no_rvalid", 32'(bi.if_rvalid), 0);
    chk("rstmid_prot_err_low", 32'(prot_err), 0);
    man_rvalid = 1'b1;
    step();
    man_rvalid = 1'b0;
    #1;
    chk("perr_after_rst", 32'(prot_err), 1);
    chk("perr_no_rvalid", 32'(bi.if_rvalid), 0);
    step(); step();
    chk("perr_sticky", 32'(prot_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
